// File: rtl/digit_serial_adder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// digit_serial_adder_if : request/result bundle for digit_serial_adder
// Revision 1.0
// ---------------------------------------------------------------------------
interface digit_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, in1, in2, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, in1, in2, cin,
    output busy, done, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// digit_serial_adder : add/subtract WIDTH-bit operands DIGIT bits per cycle
// Revision 1.0
// ---------------------------------------------------------------------------
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  digit_serial_adder_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT:0]   w_dsum;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_accept;
  logic             w_last;
  logic             w_msb_cin;

  assign w_accept   = bus.start && (r_state != RUN);
  assign w_last     = (r_state == RUN) && (r_cnt == CW'(N - 1));
  assign w_dsum     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, r_carry};
  // New digit enters at the top; after N digits the LSB digit sits at bit 0.
  assign w_acc_next = WIDTH'({w_dsum[DIGIT-1:0], r_acc} >> DIGIT);
  assign w_msb_cin  = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = bus.start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + ~borrow.
      r_a     <= bus.in1;
      r_b     <= bus.sub ? ~bus.in2 : bus.in2;
      r_carry <= bus.cin ^ bus.sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_acc_next;
      r_carry <= w_dsum[DIGIT];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_msb_cin ^ w_dsum[DIGIT];
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire
